arm_pipelined_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the 5-stage ARM pipeline (F/D/E/M/W). It generates per-port operand forwarding selects and load-use stalls. It also handles PC-write and branch flushes, multi-cycle execute-unit occupancy through a counter FSM, and data-memory wait stalls. The block sits beside the datapath and drives the stall and flush enables of every pipeline register.

---
 rtl/arm_hazard_pkg.sv | 17 +
 rtl/arm_hazard_fwd_port.sv | 36 +++
 rtl/arm_pipelined_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_arm_pipelined_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_hazard_pkg.sv
// Shared types and constants for the ARM 5-stage hazard controller.
package arm_hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } hz_state_t;

   localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/arm_hazard_fwd_port.sv
// Per read-port comparator: forward select for E and load-use hit for D.
module arm_hazard_fwd_port
   import arm_hazard_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] ra_e,
   input  logic [REG_AW-1:0] ra_d,
   input  logic [REG_AW-1:0] wa_e,
   input  logic [REG_AW-1:0] wa_m,
   input  logic [REG_AW-1:0] wa_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic              mem_to_reg_e,
   output fwd_sel_t          fwd_sel,
   output logic              ld_hit
);

   logic e_is_pc;
   logic d_is_pc;

   // PC reads come from the fetch path, never from the bypass network
   assign e_is_pc = (ra_e == REG_AW'(REG_PC));
   assign d_is_pc = (ra_d == REG_AW'(REG_PC));

   always_comb begin
      fwd_sel = FWD_RF;
      if (!e_is_pc && reg_write_m && (ra_e == wa_m))
         fwd_sel = FWD_M;
      else if (!e_is_pc && reg_write_w && (ra_e == wa_w))
         fwd_sel = FWD_W;
   end

   assign ld_hit = mem_to_reg_e && !d_is_pc && (ra_d == wa_e);

endmodule

// File: rtl/arm_pipelined_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W ARM pipeline: forwarding, stalls, flushes.
// Optional HAZARD_PERF_CNT_EN adds stall/flush event counters.
module arm_pipelined_hazard_ctrl
   import arm_hazard_pkg::*;
#(
   parameter int NUM_RD_PORTS = 3,
   parameter int REG_AW       = 4,
   parameter int MUL_LATENCY  = 4
) (
   input  logic                           i_CLK,
   input  logic                           i_RESET,
   input  logic [NUM_RD_PORTS*REG_AW-1:0] i_RA_D,
   input  logic [NUM_RD_PORTS*REG_AW-1:0] i_RA_E,
   input  logic [REG_AW-1:0]              i_WA_E,
   input  logic [REG_AW-1:0]              i_WA_M,
   input  logic [REG_AW-1:0]              i_WA_W,
   input  logic                           i_Reg_Write_M,
   input  logic                           i_Reg_Write_W,
   input  logic                           i_Mem_To_Reg_E,
   input  logic                           i_PC_Write_D,
   input  logic                           i_PC_Write_E,
   input  logic                           i_PC_Write_M,
   input  logic                           i_PC_Write_W,
   input  logic                           i_Branch_Taken_E,
   input  logic                           i_Mul_Start_E,
   input  logic                           i_Mem_Req_M,
   input  logic                           i_Mem_Ready_M,
   output logic                           o_Stall_F,
   output logic                           o_Stall_D,
   output logic                           o_Stall_E,
   output logic                           o_Stall_M,
   output logic                           o_Flush_D,
   output logic                           o_Flush_E,
   output logic                           o_Flush_M,
   output logic [NUM_RD_PORTS*2-1:0]      o_Forward_E,
   output logic                           o_Busy
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]                    o_Stall_Cnt,
   output logic [31:0]                    o_Flush_Cnt
`endif
);

   localparam int CW = $clog2(MUL_LATENCY);

   hz_state_t               state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_RD_PORTS-1:0] ld_hit;
   fwd_sel_t                fwd_sel [NUM_RD_PORTS];
   logic                    mem_wait, ldr_stall, pc_pend, mul_stall, stall_e;

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      arm_hazard_fwd_port #(.REG_AW(REG_AW)) u_port (
         .ra_e         (i_RA_E[p*REG_AW +: REG_AW]),
         .ra_d         (i_RA_D[p*REG_AW +: REG_AW]),
         .wa_e         (i_WA_E),
         .wa_m         (i_WA_M),
         .wa_w         (i_WA_W),
         .reg_write_m  (i_Reg_Write_M),
         .reg_write_w  (i_Reg_Write_W),
         .mem_to_reg_e (i_Mem_To_Reg_E),
         .fwd_sel      (fwd_sel[p]),
         .ld_hit       (ld_hit[p])
      );
      assign o_Forward_E[p*2 +: 2] = i_RESET ? FWD_RF : fwd_sel[p];
   end

   assign mem_wait  = i_Mem_Req_M & ~i_Mem_Ready_M;
   assign ldr_stall = |ld_hit;
   assign pc_pend   = i_PC_Write_D | i_PC_Write_E | i_PC_Write_M;

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mul_stall = 1'b0;
      stall_e   = 1'b0;
      o_Stall_F = 1'b0;
      o_Stall_D = 1'b0;
      o_Stall_E = 1'b0;
      o_Stall_M = 1'b0;
      o_Flush_D = 1'b0;
      o_Flush_E = 1'b0;
      o_Flush_M = 1'b0;
      o_Busy    = 1'b0;

      // cnt counts remaining stall cycles after the current one
      case (state_q)
         IDLE: begin
            if (i_Mul_Start_E) begin
               mul_stall = 1'b1;
               state_d   = MUL_BUSY;
               cnt_d     = CW'(MUL_LATENCY - 2);
            end
         end
         MUL_BUSY: begin
            if (cnt_q != '0) begin
               mul_stall = 1'b1;
               cnt_d     = cnt_q - CW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (mem_wait) begin
         state_d = state_q;
         cnt_d   = cnt_q;
      end

      if (i_RESET) begin
         o_Flush_D = 1'b1;
         o_Flush_E = 1'b1;
         o_Flush_M = 1'b1;
      end else if (mem_wait) begin
         o_Stall_F = 1'b1;
         o_Stall_D = 1'b1;
         o_Stall_E = 1'b1;
         o_Stall_M = 1'b1;
         o_Busy    = (state_q == MUL_BUSY);
      end else begin
         stall_e   = mul_stall;
         o_Stall_F = ldr_stall | pc_pend | mul_stall;
         o_Stall_D = ldr_stall | mul_stall;
         o_Stall_E = stall_e;
         o_Flush_D = pc_pend | i_PC_Write_W | i_Branch_Taken_E;
         o_Flush_E = (ldr_stall | i_Branch_Taken_E) & ~stall_e;
         o_Flush_M = mul_stall;
         o_Busy    = (state_q == MUL_BUSY);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         o_Stall_Cnt <= '0;
         o_Flush_Cnt <= '0;
      end else begin
         if (o_Stall_F)
            o_Stall_Cnt <= o_Stall_Cnt + 32'd1;
         if (o_Flush_D | o_Flush_E | o_Flush_M)
            o_Flush_Cnt <= o_Flush_Cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arm_pipelined_hazard_ctrl.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_arm_pipelined_hazard_ctrl;

   localparam int NP  = 3;
   localparam int AW  = 4;
   localparam int LAT = 4;

   typedef struct packed {
      logic        rst;
      logic [11:0] ra_d;
      logic [11:0] ra_e;
      logic [3:0]  wa_e;
      logic [3:0]  wa_m;
      logic [3:0]  wa_w;
      logic        rw_m;
      logic        rw_w;
      logic        m2r;
      logic [3:0]  pcw;   // [0]=D [1]=E [2]=M [3]=W
      logic        br;
      logic        mul;
      logic        mreq;
      logic        mrdy;
   } stim_t;

   typedef struct packed {
      logic [3:0]  stall; // F D E M
      logic [2:0]  flush; // D E M
      logic [5:0]  fwd;
      logic        busy;
      logic [31:0] scnt;
      logic [31:0] fcnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] ra_d = '0, ra_e = '0;
   logic [3:0]  wa_e = '0, wa_m = '0, wa_w = '0;
   logic        rw_m = 1'b0, rw_w = 1'b0, m2r = 1'b0;
   logic [3:0]  pcw = '0;
   logic        br = 1'b0, mul = 1'b0, mreq = 1'b0, mrdy = 1'b1;
   logic        st_f, st_d, st_e, st_m, fl_d, fl_e, fl_m, busy;
   logic [5:0]  fwd;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] scnt_o, fcnt_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   exp_t exp_q[$];

   // reference model state: remaining occupancy cycles of the mul in E
   int          left = 0;
   logic [31:0] m_scnt = '0, m_fcnt = '0;
   stim_t       prev_s;
   exp_t        prev_e;

   always #5 clk = ~clk;

   arm_pipelined_hazard_ctrl #(.NUM_RD_PORTS(NP), .REG_AW(AW), .MUL_LATENCY(LAT)) dut (
      .i_CLK(clk), .i_RESET(rst), .i_RA_D(ra_d), .i_RA_E(ra_e),
      .i_WA_E(wa_e), .i_WA_M(wa_m), .i_WA_W(wa_w),
      .i_Reg_Write_M(rw_m), .i_Reg_Write_W(rw_w), .i_Mem_To_Reg_E(m2r),
      .i_PC_Write_D(pcw[0]), .i_PC_Write_E(pcw[1]), .i_PC_Write_M(pcw[2]), .i_PC_Write_W(pcw[3]),
      .i_Branch_Taken_E(br), .i_Mul_Start_E(mul), .i_Mem_Req_M(mreq), .i_Mem_Ready_M(mrdy),
      .o_Stall_F(st_f), .o_Stall_D(st_d), .o_Stall_E(st_e), .o_Stall_M(st_m),
      .o_Flush_D(fl_d), .o_Flush_E(fl_e), .o_Flush_M(fl_m),
      .o_Forward_E(fwd), .o_Busy(busy)
`ifdef HAZARD_PERF_CNT_EN
     ,.o_Stall_Cnt(scnt_o), .o_Flush_Cnt(fcnt_o)
`endif
   );

   function automatic exp_t model(input stim_t s, input int lft);
      exp_t e;
      logic ldr, pcp, mw, ms;
      logic [3:0] a;
      e = '0;
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
      if (s.rst) begin
         e.flush = 3'b111;
         return e;
      end
      mw  = s.mreq && !s.mrdy;
      ldr = 1'b0;
      for (int p = 0; p < NP; p++) begin
         a = s.ra_d[p*4 +: 4];
         if (s.m2r && a == s.wa_e && a != 4'hF) ldr = 1'b1;
         a = s.ra_e[p*4 +: 4];
         if (a != 4'hF && s.rw_m && a == s.wa_m)      e.fwd[p*2 +: 2] = 2'b10;
         else if (a != 4'hF && s.rw_w && a == s.wa_w) e.fwd[p*2 +: 2] = 2'b01;
      end
      // an op stalls E on every occupancy cycle except its last
      ms  = (lft == 0) ? s.mul : (lft > 1);
      pcp = |s.pcw[2:0];
      e.busy = (lft > 0);
      if (mw) begin
         e.stall = 4'b1111;
      end else begin
         e.stall = {ldr | pcp | ms, ldr | ms, ms, 1'b0};
         e.flush = {pcp | s.pcw[3] | s.br, (ldr | s.br) & !ms, ms};
      end
      return e;
   endfunction

   task automatic drive(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      if (prev_s.rst) begin
         left   = 0;
         m_scnt = '0;
         m_fcnt = '0;
      end else begin
         m_scnt = m_scnt + {31'd0, prev_e.stall[3]};
         m_fcnt = m_fcnt + {31'd0, |prev_e.flush};
         if (!(prev_s.mreq && !prev_s.mrdy)) begin
            if (left == 0) begin
               if (prev_s.mul) left = LAT - 1;
            end else begin
               left = left - 1;
            end
         end
      end
      rst = s.rst; ra_d = s.ra_d; ra_e = s.ra_e;
      wa_e = s.wa_e; wa_m = s.wa_m; wa_w = s.wa_w;
      rw_m = s.rw_m; rw_w = s.rw_w; m2r = s.m2r; pcw = s.pcw;
      br = s.br; mul = s.mul; mreq = s.mreq; mrdy = s.mrdy;
      e = model(s, left);
      exp_q.push_back(e);
      prev_s = s;
      prev_e = e;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 64'({st_f, st_d, st_e, st_m}), 64'(e.stall));
            chk("flush", 64'({fl_d, fl_e, fl_m}), 64'(e.flush));
            chk("forward", 64'(fwd), 64'(e.fwd));
            chk("busy", 64'(busy), 64'(e.busy));
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cnt", 64'(scnt_o), 64'(e.scnt));
            chk("flush_cnt", 64'(fcnt_o), 64'(e.fcnt));
`endif
         end
      end
   end

   function automatic logic [3:0] raddr();
      case ($urandom_range(0, 3))
         0:       return 4'd3;
         1:       return 4'd5;
         2:       return 4'hF;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      stim_t s;
      prev_s = '0;
      prev_s.rst = 1'b1;
      prev_e = '0;

      s = '0; s.rst = 1'b1; s.mrdy = 1'b1;
      drive(s); drive(s);

      s = '0; s.mrdy = 1'b1;
      s.ra_e[3:0] = 4'd3; s.wa_m = 4'd3; s.rw_m = 1'b1; s.wa_w = 4'd3; s.rw_w = 1'b1;
      drive(s);
      s.rw_m = 1'b0;
      drive(s);
      s.ra_e[3:0] = 4'hF; s.wa_w = 4'hF;
      drive(s);

      s = '0; s.mrdy = 1'b1;
      s.ra_d[7:4] = 4'd5; s.wa_e = 4'd5; s.m2r = 1'b1;
      drive(s);
      s.ra_d[7:4] = 4'hF; s.wa_e = 4'hF;
      drive(s);

      // held mul start: back-to-back ops
      s = '0; s.mrdy = 1'b1; s.mul = 1'b1;
      repeat (9) drive(s);
      s.mul = 1'b0;
      repeat (4) drive(s);

      // mul interrupted by two memory wait cycles
      s.mul = 1'b1; drive(s);
      s.mul = 1'b0; drive(s);
      s.mreq = 1'b1; s.mrdy = 1'b0; s.br = 1'b1; s.pcw = 4'b1111;
      repeat (2) drive(s);
      s.mreq = 1'b0; s.mrdy = 1'b1; s.br = 1'b0; s.pcw = '0;
      repeat (4) drive(s);

      for (int i = 0; i < 4; i++) begin
         s.pcw = 4'b0001 << i;
         drive(s);
      end
      s.pcw = '0; s.br = 1'b1; drive(s);
      s.br = 1'b0; drive(s);

      // reset in the middle of a busy period
      s.mul = 1'b1; drive(s);
      s.mul = 1'b0; drive(s);
      s.rst = 1'b1; drive(s);
      s.rst = 1'b0; drive(s); drive(s);

      for (int i = 0; i < 1500; i++) begin
         s.rst = ($urandom_range(0, 39) == 0);
         for (int p = 0; p < NP; p++) begin
            s.ra_d[p*4 +: 4] = raddr();
            s.ra_e[p*4 +: 4] = raddr();
         end
         s.wa_e = raddr(); s.wa_m = raddr(); s.wa_w = raddr();
         s.rw_m = ($urandom_range(0, 1) == 1);
         s.rw_w = ($urandom_range(0, 1) == 1);
         s.m2r  = ($urandom_range(0, 2) == 0);
         for (int b = 0; b < 4; b++) s.pcw[b] = ($urandom_range(0, 7) == 0);
         s.br   = ($urandom_range(0, 7) == 0);
         s.mul  = ($urandom_range(0, 3) == 0);
         s.mreq = ($urandom_range(0, 1) == 1);
         s.mrdy = ($urandom_range(0, 2) != 0);
         drive(s);
      end

      @(negedge clk);
      @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
